rtc_bus_sequencer: RTL and testbench
====================================

# rtc_bus_sequencer

Sequences single-byte transactions on the multiplexed address/data bus of the real-time-clock chip (AD, CS, WR, RD, shared 8-bit `salient` bus) on behalf of the PicoBlaze port logic. A request (address, direction, write data) is converted into a fixed address phase followed by a data phase, each with setup, strobe and hold sub-phases of programmable length. The block sits between the PicoBlaze I/O decode and the top-level tristate pad for `salient`; the pad itself is instantiated at top level.

## Interface
- `PHASE_CYCLES`, 10, clk cycles per sub-phase (≥1); 10 gives 100 ns at 100 MHz
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request strobe, sampled when `busy`=0
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  8  RTC register address
- `req_wdata`  in  8  write data
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle completion pulse
- `rdata`  out  8  last read byte, held until next read
- `AD`  out  1  0 = address phase, 1 = data phase
- `CS`  out  1  chip select, active low
- `WR`  out  1  write strobe, active low
- `RD`  out  1  read strobe, active low
- `bus_out`  out  8  value driven onto `salient`
- `bus_oe`  out  1  1 = top level drives `salient` with `bus_out`
- `bus_in`  in  8  `salient` as seen at the pad

## Operation
- States: IDLE, ADDR_SU, ADDR_STB, ADDR_HD, DATA_SU, DATA_STB, DATA_HD, DONE.
- IDLE: `req_valid`=1 latches addr/wdata/write into internal registers, moves to ADDR_SU. `req_valid` while not IDLE is ignored (no queueing).
- Each state ADDR_SU … DATA_HD lasts exactly `PHASE_CYCLES` cycles (down-counter reloaded on entry); DONE lasts 1 cycle, then IDLE.
- Outputs per state (all registered, Moore):
  - IDLE/DONE: AD=1, CS=1, WR=1, RD=1, bus_oe=0.
  - ADDR_SU/ADDR_HD: AD=0, CS=0, WR=1, bus_oe=1, bus_out=addr.
  - ADDR_STB: AD=0, CS=0, WR=0, bus_oe=1, bus_out=addr.
  - DATA_SU/DATA_HD: AD=1, CS=0, WR=1, RD=1; write: bus_oe=1, bus_out=wdata; read: bus_oe=0.
  - DATA_STB: AD=1, CS=0; write: WR=0, bus_oe=1; read: RD=0, bus_oe=0.
- Read capture: `rdata` <= `bus_in` on the last cycle of DATA_STB (edge that leaves DATA_STB). Writes never modify `rdata`.
- `busy`=1 in every state except IDLE; `done`=1 only in DONE.
- `bus_out`=0 whenever bus_oe=0.
- Reset (any time, including mid-transaction): state IDLE, AD=CS=WR=RD=1, bus_oe=0, bus_out=0, busy=0, done=0, rdata=0x00, counter cleared; asserted asynchronously, no partial strobe survives.

## Timing
- Request accepted on edge E0 (IDLE, `req_valid`=1); `busy` high from the cycle after E0.
- With P=`PHASE_CYCLES`, cycle index k after E0: ADDR_SU k=1..P, ADDR_STB P+1..2P, ADDR_HD 2P+1..3P, DATA_SU 3P+1..4P, DATA_STB 4P+1..5P, DATA_HD 5P+1..6P, DONE 6P+1, IDLE 6P+2.
- `done` rises at k=6P+1 for one cycle; `rdata` valid from k=5P+1 onward.
- Next request earliest accepted at edge ending cycle 6P+2 (first IDLE cycle); throughput one transaction per 6P+2 cycles.
- Strobes never overlap: WR and RD never both 0; AD changes only while WR=RD=1.

## Structure
- Package `rtc_bus_pkg`: state enum, strobe inactive level constant (1), AD address/data level constants.
- Sub-module `phase_timer`: loadable down-counter, width $clog2(PHASE_CYCLES+1), output `expired` on last cycle of a sub-phase; FSM and output registers in `rtc_bus_sequencer`.

## Test plan
- P=4, write addr 0x21 data 0x45: ADDR_STB k=5..8 with WR=0, AD=0, bus_out=0x21; DATA_STB k=17..20 with WR=0, AD=1, bus_out=0x45; done at k=25; rdata stays 0x00.
- P=4, read addr 0x22, bus_in=0x17 during DATA_STB: RD=0 k=17..20, bus_oe=0 k=13..24, rdata=0x17 from k=21, done k=25, WR never 0 in data phase.
- Second `req_valid` (write 0x30) at k=3 of a running read: ignored; bus sequence and done timing unchanged; no second transaction follows.
- Reset asserted at k=18 of a write: asynchronously CS=WR=RD=AD=1, bus_oe=0, busy=0; after release a new read completes normally.
- Back-to-back: request held high continuously, P=1: transactions accepted every 8 cycles, done pulses 8 cycles apart, CS returns high for ≥1 cycle between them.
- P=1 read/write pair: each sub-phase exactly 1 cycle, done at k=7, rdata captured correctly.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared types and bus levels for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

    // Transaction phases; each of ADDR_SU..DATA_HD lasts one programmable sub-phase.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR_SU  = 3'd1,
        ST_ADDR_STB = 3'd2,
        ST_ADDR_HD  = 3'd3,
        ST_DATA_SU  = 3'd4,
        ST_DATA_STB = 3'd5,
        ST_DATA_HD  = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    // Strobes (CS, WR, RD) are active low.
    localparam logic STROBE_OFF = 1'b1;
    localparam logic STROBE_ON  = 1'b0;

    // AD pin level selecting address or data phase.
    localparam logic AD_ADDR = 1'b0;
    localparam logic AD_DATA = 1'b1;

    // True for the six states whose length is set by the phase timer.
    function automatic logic is_timed(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Loadable down-counter timing one sub-phase of PHASE_CYCLES clocks.
module phase_timer #(
    parameter int PHASE_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int W = $clog2(PHASE_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(PHASE_CYCLES - 1);

    logic [W-1:0] count;

    // Reload on sub-phase entry, then count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Zero marks the last cycle of the current sub-phase.
    assign expired = (count == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Converts single-byte RTC requests into an address phase and a data phase,
// each split into setup, strobe and hold sub-phases on the multiplexed bus.
//
// Request handshake: req_valid is sampled only while busy=0; a request seen
// in IDLE is accepted on that clock edge and no acknowledge is returned.
// Requests arriving while busy=1 are dropped. done pulses for one cycle when
// the transaction ends, and rdata then holds the last byte read.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       AD,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    output logic [2:0] dbg_state
);

    state_t     state;
    state_t     state_nxt;
    logic       expired;
    logic       start;
    logic       timer_load;
    logic       write_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_nxt;
    logic [7:0] addr_nxt;
    logic [7:0] wdata_nxt;
    logic       ad_d;
    logic       cs_d;
    logic       wr_d;
    logic       rd_d;
    logic       oe_d;
    logic [7:0] out_d;

    assign start      = (state == ST_IDLE) && req_valid;
    assign timer_load = start || (is_timed(state) && expired);
    assign dbg_state  = state;

    // Request fields as they will be after this edge, so the first
    // address-phase cycle already drives the new address.
    assign write_nxt = start ? req_write : write_q;
    assign addr_nxt  = start ? req_addr  : addr_q;
    assign wdata_nxt = start ? req_wdata : wdata_q;

    phase_timer #(
        .PHASE_CYCLES(PHASE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .expired(expired)
    );

    // Next-state: timed states advance when the sub-phase expires.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (req_valid) state_nxt = ST_ADDR_SU;
            ST_ADDR_SU:  if (expired)   state_nxt = ST_ADDR_STB;
            ST_ADDR_STB: if (expired)   state_nxt = ST_ADDR_HD;
            ST_ADDR_HD:  if (expired)   state_nxt = ST_DATA_SU;
            ST_DATA_SU:  if (expired)   state_nxt = ST_DATA_STB;
            ST_DATA_STB: if (expired)   state_nxt = ST_DATA_HD;
            ST_DATA_HD:  if (expired)   state_nxt = ST_DONE;
            ST_DONE:                    state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Pin levels for the upcoming state; bus_out is forced to zero whenever
    // the pad is not being driven.
    always_comb begin
        ad_d  = AD_DATA;
        cs_d  = STROBE_OFF;
        wr_d  = STROBE_OFF;
        rd_d  = STROBE_OFF;
        oe_d  = 1'b0;
        out_d = 8'h00;
        case (state_nxt)
            ST_ADDR_SU, ST_ADDR_HD: begin
                ad_d  = AD_ADDR;
                cs_d  = STROBE_ON;
                oe_d  = 1'b1;
                out_d = addr_nxt;
            end
            ST_ADDR_STB: begin
                ad_d  = AD_ADDR;
                cs_d  = STROBE_ON;
                wr_d  = STROBE_ON;
                oe_d  = 1'b1;
                out_d = addr_nxt;
            end
            ST_DATA_SU, ST_DATA_HD: begin
                cs_d = STROBE_ON;
                if (write_nxt) begin
                    oe_d  = 1'b1;
                    out_d = wdata_nxt;
                end
            end
            ST_DATA_STB: begin
                cs_d = STROBE_ON;
                if (write_nxt) begin
                    wr_d  = STROBE_ON;
                    oe_d  = 1'b1;
                    out_d = wdata_nxt;
                end else begin
                    rd_d = STROBE_ON;
                end
            end
            default: begin
            end
        endcase
    end

    // State, latched request and registered Moore outputs; reset clears every
    // strobe immediately so no partial cycle reaches the chip.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            write_q <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= 8'h00;
            AD      <= AD_DATA;
            CS      <= STROBE_OFF;
            WR      <= STROBE_OFF;
            RD      <= STROBE_OFF;
            bus_oe  <= 1'b0;
            bus_out <= 8'h00;
        end else begin
            state   <= state_nxt;
            write_q <= write_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            AD      <= ad_d;
            CS      <= cs_d;
            WR      <= wr_d;
            RD      <= rd_d;
            bus_oe  <= oe_d;
            bus_out <= out_d;
            if ((state == ST_DATA_STB) && expired && !write_q) begin
                rdata <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: one instance with 4-cycle sub-phases and one
// with 1-cycle sub-phases, checked against a cycle-index timing model and a
// done/rdata scoreboard.
module tb_rtc_bus_sequencer;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         compared = 0;
    int         failed = 0;

    logic       reset     [2];
    logic       req_valid [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       busy      [2];
    logic       done      [2];
    logic [7:0] rdata     [2];
    logic       ad        [2];
    logic       cs        [2];
    logic       wr        [2];
    logic       rd        [2];
    logic [7:0] bus_out   [2];
    logic       bus_oe    [2];
    logic [7:0] bus_in    [2];
    logic [2:0] dbg_state [2];

    // Per-DUT model of the transaction in flight.
    bit         active    [2];
    int         t0        [2];
    logic       m_wr      [2];
    logic [7:0] m_addr    [2];
    logic [7:0] m_wdata   [2];
    logic [7:0] m_rval    [2];
    logic [7:0] rdata_exp [2];
    logic [7:0] last_read [2];

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    localparam logic [14:0] IDLE_PAT = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    rtc_bus_sequencer #(.PHASE_CYCLES(4)) u_dut4 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]), .done(done[0]),
        .rdata(rdata[0]), .AD(ad[0]), .CS(cs[0]), .WR(wr[0]), .RD(rd[0]),
        .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0]), .dbg_state(dbg_state[0])
    );

    rtc_bus_sequencer #(.PHASE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]), .done(done[1]),
        .rdata(rdata[1]), .AD(ad[1]), .CS(cs[1]), .WR(wr[1]), .RD(rd[1]),
        .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1]), .dbg_state(dbg_state[1])
    );

    function automatic int pp(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected {busy, done, AD, CS, WR, RD, bus_oe, bus_out} at cycle k after acceptance.
    function automatic logic [14:0] model(input int k, input int p, input logic w,
                                          input logic [7:0] a, input logic [7:0] d);
        int ph;
        logic [7:0] dv;
        dv = w ? d : 8'h00;
        if (k < 1 || k > 6 * p + 1) return IDLE_PAT;
        if (k == 6 * p + 1) return {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        ph = (k - 1) / p;
        case (ph)
            0, 2:    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, a};
            1:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a};
            3, 5:    return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, w, dv};
            default: return {1'b1, 1'b0, 1'b1, 1'b0, ~w, w, w, dv};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the request is taken on the next edge.
    task automatic issue(input int i, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] rv, input bit hold);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        t0[i]        = cyc;
        m_wr[i]      = w;
        m_addr[i]    = a;
        m_wdata[i]   = d;
        m_rval[i]    = rv;
        active[i]    = 1'b1;
        if (!w) last_read[i] = rv;
        if (i == 0) exp_q0.push_back(last_read[i]);
        else        exp_q1.push_back(last_read[i]);
        if (!hold) begin
            tick(1);
            req_valid[i] = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int i);
        int k;
        int p;
        logic [14:0] e;
        logic [14:0] act;
        logic [7:0] ev;
        bit empty;
        if (!active[i]) return;
        p = pp(i);
        k = cyc - t0[i];
        e = model(k, p, m_wr[i], m_addr[i], m_wdata[i]);
        act = {busy[i], done[i], ad[i], cs[i], wr[i], rd[i], bus_oe[i], bus_out[i]};
        compared++;
        if (act !== e) begin
            failed++;
            $display("FAIL pins dut%0d k=%0d: got %h required %h (busy,done,AD,CS,WR,RD,oe,bus)",
                     i, k, act, e);
        end
        if (!m_wr[i] && k == 5 * p + 1) rdata_exp[i] = m_rval[i];
        compared++;
        if (rdata[i] !== rdata_exp[i]) begin
            failed++;
            $display("FAIL rdata_hold dut%0d k=%0d: got %h required %h", i, k, rdata[i], rdata_exp[i]);
        end
        if (done[i] === 1'b1) begin
            empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
            compared++;
            if (empty) begin
                failed++;
                $display("FAIL unexpected_done dut%0d k=%0d: done=1 required no transaction", i, k);
            end else begin
                ev = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                if (rdata[i] !== ev) begin
                    failed++;
                    $display("FAIL done_rdata dut%0d: got %h required %h", i, rdata[i], ev);
                end
            end
        end
        bus_in[i] = (!m_wr[i] && k >= 4 * p + 1 && k <= 5 * p) ? m_rval[i] : 8'hEE;
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    task automatic check_reset_state(input int i, input string name);
        logic [14:0] act;
        act = {busy[i], done[i], ad[i], cs[i], wr[i], rd[i], bus_oe[i], bus_out[i]};
        compared++;
        if (act !== IDLE_PAT) begin
            failed++;
            $display("FAIL %s_pins dut%0d: got %h required %h", name, i, act, IDLE_PAT);
        end
        compared++;
        if (rdata[i] !== 8'h00) begin
            failed++;
            $display("FAIL %s_rdata dut%0d: got %h required 00", name, i, rdata[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 8'h00;
            req_wdata[i] = 8'h00;
            bus_in[i]    = 8'hEE;
            active[i]    = 1'b0;
            t0[i]        = 0;
            m_wr[i]      = 1'b0;
            m_addr[i]    = 8'h00;
            m_wdata[i]   = 8'h00;
            m_rval[i]    = 8'h00;
            rdata_exp[i] = 8'h00;
            last_read[i] = 8'h00;
        end
        tick(3);
        check_reset_state(0, "reset");
        check_reset_state(1, "reset");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick(2);

        // P=4 write 0x21 <- 0x45
        issue(0, 1'b1, 8'h21, 8'h45, 8'h00, 1'b0);
        tick(30);
        // P=4 read 0x22, pad shows 0x17 during the read strobe
        issue(0, 1'b0, 8'h22, 8'h00, 8'h17, 1'b0);
        tick(30);
        // P=4 read with a stray write request at k=3 that must be dropped
        issue(0, 1'b0, 8'h3C, 8'h00, 8'hA6, 1'b0);
        tick(2);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 8'h30;
        req_wdata[0] = 8'h99;
        tick(1);
        req_valid[0] = 1'b0;
        tick(34);
        // P=4 write interrupted by reset at k=18
        issue(0, 1'b1, 8'h5A, 8'hC3, 8'h00, 1'b0);
        tick(17);
        #2;
        active[0] = 1'b0;
        reset[0]  = 1'b1;
        #1;
        check_reset_state(0, "async_reset");
        exp_q0.delete();
        last_read[0] = 8'h00;
        rdata_exp[0] = 8'h00;
        tick(2);
        reset[0] = 1'b0;
        tick(2);
        // P=4 read after reset
        issue(0, 1'b0, 8'h0F, 8'h00, 8'h81, 1'b0);
        tick(30);

        // P=1 read then write
        issue(1, 1'b0, 8'h11, 8'h00, 8'h5C, 1'b0);
        tick(10);
        issue(1, 1'b1, 8'h12, 8'hE7, 8'h00, 1'b0);
        tick(10);
        // P=1 back-to-back with req_valid held high: accepted every 8 cycles
        for (int j = 0; j < 4; j++) begin
            issue(1, j[0], 8'h40 + 8'(j), 8'hB0 + 8'(j), 8'h60 + 8'(j), 1'b1);
            tick(8);
        end
        req_valid[1] = 1'b0;
        tick(12);

        compared++;
        if (exp_q0.size() != 0) begin
            failed++;
            $display("FAIL missing_done dut0: %0d outstanding required 0", exp_q0.size());
        end
        compared++;
        if (exp_q1.size() != 0) begin
            failed++;
            $display("FAIL missing_done dut1: %0d outstanding required 0", exp_q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
